branch_pred_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 24 ++
 rtl/branch_cond_eval.sv | 33 +++
 rtl/branch_pred_unit.sv | 136 +++++++++++++
 tb/tb_branch_pred_unit.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions for the branch prediction and resolution logic.
//   cond_e      : 3-bit branch condition codes (instr[11:9])
//   FLAG_*      : bit positions of the latched Z/V/N flags
//   PC_INCR_DEF : default fall-through PC increment
package cpu_pkg;

  typedef enum logic [2:0] {
    COND_NE = 3'b000,
    COND_EQ = 3'b001,
    COND_GT = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_LE = 3'b101,
    COND_OV = 3'b110,
    COND_AL = 3'b111
  } cond_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  localparam int PC_INCR_DEF = 4;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator.
//   cond  in  3  condition code
//   flags in  3  latched flags (Z, V, N at FLAG_* positions)
//   taken out 1  condition holds
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z, v, n;

  always_comb begin
    z     = flags[FLAG_Z];
    v     = flags[FLAG_V];
    n     = flags[FLAG_N];
    taken = 1'b0;
    case (cond_e'(cond))
      COND_NE: taken = ~z;
      COND_EQ: taken = z;
      COND_GT: taken = ~(z | n);
      COND_LT: taken = n;
      COND_GE: taken = z | ~n;
      COND_LE: taken = n | z;
      COND_OV: taken = v;
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Branch prediction (fetch side) and resolution (EX/MEM side) unit.
// Direct-mapped BTB plus saturating-counter table, bimodal (GHR_W=0) or
// gshare (GHR_W>0) indexing.
//   clk, rst                         clock, synchronous active-high reset
//   if_valid, if_stall, if_pc        fetch lookup request
//   pred_taken, pred_target          prediction for if_pc (same cycle)
//   pred_hist                        history snapshot travelling with the instr
//   rs_valid, rs_is_branch, rs_pc    resolving instruction
//   rs_cond, rs_flags, rs_target     condition, latched flags, computed target
//   rs_pred_taken/target, rs_hist    prediction carried from fetch
//   actual_taken, mispredict         resolution outcome / flush request
//   redirect_pc                      correct next PC on mispredict
module branch_pred_unit
  import cpu_pkg::*;
#(
  parameter  int ENTRIES = 16,
  parameter  int PC_W    = 16,
  parameter  int CNT_W   = 2,
  parameter  int GHR_W   = 0,
  parameter  int PC_INCR = PC_INCR_DEF,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int HW      = (GHR_W > 0) ? GHR_W : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic            if_stall,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  output logic [HW-1:0]   pred_hist,
  input  logic            rs_valid,
  input  logic            rs_is_branch,
  input  logic [PC_W-1:0] rs_pc,
  input  logic [2:0]      rs_cond,
  input  logic [2:0]      rs_flags,
  input  logic [PC_W-1:0] rs_target,
  input  logic            rs_pred_taken,
  input  logic [PC_W-1:0] rs_pred_target,
  input  logic [HW-1:0]   rs_hist,
  output logic            actual_taken,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc
);

  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int CINIT = (1 << (CNT_W - 1)) - 1;

  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [PC_W-1:0]    btb_target [ENTRIES];
  logic [CNT_W-1:0]   cnt        [ENTRIES];
  logic [HW-1:0]      ghr;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] rs_idx;
  logic             if_hit;
  logic             cond_true;

  // History is XORed into the upper index bits in gshare mode.
  function automatic logic [IDX_W-1:0] tbl_idx(input logic [PC_W-1:0] pc,
                                                input logic [HW-1:0]   h);
    logic [IDX_W-1:0] mix;
    mix = '0;
    if (GHR_W > 0) mix = IDX_W'(h) << (IDX_W - GHR_W);
    return pc[IDX_W+1:2] ^ mix;
  endfunction

  // Fetch-side lookup: purely from registered tables, no write bypass.
  always_comb begin
    if_idx      = tbl_idx(if_pc, ghr);
    if_hit      = btb_valid[if_idx] && (btb_tag[if_idx] == if_pc[PC_W-1:IDX_W+2]);
    pred_taken  = if_valid & if_hit & cnt[if_idx][CNT_W-1];
    pred_target = pred_taken ? btb_target[if_idx] : '0;
    pred_hist   = ghr;
  end

  branch_cond_eval u_cond (
    .cond  (rs_cond),
    .flags (rs_flags),
    .taken (cond_true)
  );

  always_comb begin
    rs_idx       = tbl_idx(rs_pc, rs_hist);
    actual_taken = rs_valid & rs_is_branch & cond_true;
    mispredict   = rs_valid & ((actual_taken != rs_pred_taken) |
                               (actual_taken & (rs_target != rs_pred_target)));
    if (!rs_valid)        redirect_pc = '0;
    else if (actual_taken) redirect_pc = rs_target;
    else                   redirect_pc = rs_pc + PC_W'(PC_INCR);
  end

  // Tag/target need no reset: they are only observed through btb_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) cnt[i] <= CNT_W'(CINIT);
    end else if (rs_valid) begin
      if (rs_is_branch) begin
        if (actual_taken) begin
          if (cnt[rs_idx] != CNT_W'(CMAX)) cnt[rs_idx] <= cnt[rs_idx] + CNT_W'(1);
          btb_valid[rs_idx]  <= 1'b1;
          btb_tag[rs_idx]    <= rs_pc[PC_W-1:IDX_W+2];
          btb_target[rs_idx] <= rs_target;
        end else if (cnt[rs_idx] != '0) begin
          cnt[rs_idx] <= cnt[rs_idx] - CNT_W'(1);
        end
      end else if (rs_pred_taken) begin
        // A non-branch hit the BTB through aliasing: drop the stale entry.
        btb_valid[rs_idx] <= 1'b0;
      end
    end
  end

  generate
    if (GHR_W > 0) begin : g_ghr
      always_ff @(posedge clk) begin
        if (rst) begin
          ghr <= '0;
        end else if (mispredict & rs_is_branch) begin
          ghr <= HW'({rs_hist, actual_taken});
        end else if (if_valid & ~if_stall & ~mispredict) begin
          ghr <= HW'({ghr, pred_taken});
        end
      end
    end else begin : g_no_ghr
      assign ghr = '0;
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], rs_pc[1:0], if_stall, rs_hist};

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench: a bimodal instance (defaults) and a gshare instance
// (GHR_W=4) share fetch/resolve stimulus; both are compared every cycle
// against an array-based model of the prediction/resolution rules.
module tb_branch_pred_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_stall;
  logic [15:0] if_pc;
  logic        rs_valid, rs_is_branch;
  logic [15:0] rs_pc;
  logic [2:0]  rs_cond, rs_flags;
  logic [15:0] rs_target;

  logic        rpt0, rpt1;
  logic [15:0] rptg0, rptg1;
  logic [0:0]  rh0;
  logic [3:0]  rh1;

  logic        pt0, pt1, at0, at1, mp0, mp1;
  logic [15:0] ptg0, ptg1, rd0, rd1;
  logic [0:0]  ph0;
  logic [3:0]  ph1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_pred_unit dut0 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_stall(if_stall), .if_pc(if_pc),
    .pred_taken(pt0), .pred_target(ptg0), .pred_hist(ph0),
    .rs_valid(rs_valid), .rs_is_branch(rs_is_branch), .rs_pc(rs_pc), .rs_cond(rs_cond),
    .rs_flags(rs_flags), .rs_target(rs_target), .rs_pred_taken(rpt0),
    .rs_pred_target(rptg0), .rs_hist(rh0),
    .actual_taken(at0), .mispredict(mp0), .redirect_pc(rd0)
  );

  branch_pred_unit #(.GHR_W(4)) dut1 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_stall(if_stall), .if_pc(if_pc),
    .pred_taken(pt1), .pred_target(ptg1), .pred_hist(ph1),
    .rs_valid(rs_valid), .rs_is_branch(rs_is_branch), .rs_pc(rs_pc), .rs_cond(rs_cond),
    .rs_flags(rs_flags), .rs_target(rs_target), .rs_pred_taken(rpt1),
    .rs_pred_target(rptg1), .rs_hist(rh1),
    .actual_taken(at1), .mispredict(mp1), .redirect_pc(rd1)
  );

  // ---------------- behavioural model ----------------
  int mv   [2][16];
  int mtag [2][16];
  int mtgt [2][16];
  int mcnt [2][16];
  int mghr [2];
  int gw   [2] = '{0, 4};

  function automatic int midx(int d, int pc, int h);
    int b;
    b = (pc / 4) % 16;
    if (gw[d] > 0) b = b ^ ((h << (4 - gw[d])) & 15);
    return b;
  endfunction

  function automatic int cond_ok(int c, int f);
    int z, v, n;
    z = f & 1; v = (f >> 1) & 1; n = (f >> 2) & 1;
    case (c)
      0: return (z == 0);
      1: return (z == 1);
      2: return (z == 0 && n == 0);
      3: return (n == 1);
      4: return (z == 1 || n == 0);
      5: return (n == 1 || z == 1);
      6: return (v == 1);
      default: return 1;
    endcase
  endfunction

  function automatic int mlook(int d, int pc, int h, output int tgt);
    int i;
    i = midx(d, pc, h);
    tgt = 0;
    if (mv[d][i] != 0 && mtag[d][i] == pc / 64 && mcnt[d][i] >= 2) begin
      tgt = mtgt[d][i];
      return 1;
    end
    return 0;
  endfunction

  function automatic int r_pt(int d);   return d ? int'(rpt1) : int'(rpt0);   endfunction
  function automatic int r_ptg(int d);  return d ? int'(rptg1) : int'(rptg0); endfunction
  function automatic int r_h(int d);    return d ? int'(rh1) : int'(rh0);     endfunction

  function automatic int m_act(int d);
    return (rs_valid && rs_is_branch && cond_ok(int'(rs_cond), int'(rs_flags))) ? 1 : 0;
  endfunction

  function automatic int m_misp(int d);
    int a;
    a = m_act(d);
    if (!rs_valid) return 0;
    return (a != r_pt(d) || (a == 1 && int'(rs_target) != r_ptg(d))) ? 1 : 0;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        mv[d][i] = 0; mcnt[d][i] = 1; mtag[d][i] = 0; mtgt[d][i] = 0;
      end
      mghr[d] = 0;
    end
  endtask

  task automatic m_apply();
    int pr, tg, a, mp, i;
    if (rst) begin
      m_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      pr = if_valid ? mlook(d, int'(if_pc), mghr[d], tg) : 0;
      a  = m_act(d);
      mp = m_misp(d);
      i  = midx(d, int'(rs_pc), r_h(d));
      if (rs_valid && rs_is_branch) begin
        if (a) begin
          mcnt[d][i] = (mcnt[d][i] < 3) ? mcnt[d][i] + 1 : 3;
          mv[d][i] = 1; mtag[d][i] = int'(rs_pc) / 64; mtgt[d][i] = int'(rs_target);
        end else begin
          mcnt[d][i] = (mcnt[d][i] > 0) ? mcnt[d][i] - 1 : 0;
        end
      end else if (rs_valid && r_pt(d) != 0) begin
        mv[d][i] = 0;
      end
      if (gw[d] > 0) begin
        if (mp && rs_is_branch)                  mghr[d] = ((r_h(d) << 1) | a) & 15;
        else if (if_valid && !if_stall && !mp)   mghr[d] = ((mghr[d] << 1) | pr) & 15;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int pr, tg, redir;
    #1;
    for (int d = 0; d < 2; d++) begin
      pr = if_valid ? mlook(d, int'(if_pc), mghr[d], tg) : 0;
      if (!pr) tg = 0;
      if (!rs_valid)     redir = 0;
      else if (m_act(d)) redir = int'(rs_target);
      else               redir = (int'(rs_pc) + 4) & 16'hFFFF;
      chk(d ? "pred_taken1" : "pred_taken0", d ? pt1 : pt0, pr);
      chk(d ? "pred_target1" : "pred_target0", d ? ptg1 : ptg0, tg);
      chk(d ? "actual1" : "actual0", d ? at1 : at0, m_act(d));
      chk(d ? "mispredict1" : "mispredict0", d ? mp1 : mp0, m_misp(d));
      chk(d ? "redirect1" : "redirect0", d ? rd1 : rd0, redir);
      if (gw[d] > 0) chk("pred_hist1", ph1, mghr[d]);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_apply();
    @(negedge clk);
  endtask

  task automatic idle();
    rs_valid = 0; rs_is_branch = 0; rs_pc = 0; rs_cond = 0; rs_flags = 0; rs_target = 0;
    rpt0 = 0; rpt1 = 0; rptg0 = 0; rptg1 = 0; rh0 = 0; rh1 = 0;
  endtask

  task automatic resolve(input logic [15:0] pc, input logic [2:0] c, input logic [2:0] f,
                         input logic [15:0] tgt, input logic p, input logic [15:0] ptg);
    rs_valid = 1; rs_is_branch = 1; rs_pc = pc; rs_cond = c; rs_flags = f; rs_target = tgt;
    rpt0 = p; rpt1 = p; rptg0 = ptg; rptg1 = ptg; rh0 = 0; rh1 = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int tg;
    rst = 1; if_valid = 0; if_stall = 0; if_pc = 0;
    idle();
    @(negedge clk);
    advance();
    advance();
    rst = 0;

    // reset state
    if_valid = 1; if_pc = 16'h0010;
    check_all();
    chk("rst_pred", pt0, 0);
    chk("rst_misp", mp0, 0);
    advance();

    // always-taken branch, predicted not taken; same-cycle lookup sees old state
    resolve(16'h0010, 3'b111, 3'b000, 16'h0040, 0, 16'h0000);
    check_all();
    chk("first_misp", mp0, 1);
    chk("first_redirect", rd0, 16'h0040);
    chk("no_bypass", pt0, 0);
    advance();

    idle();
    check_all();
    chk("trained_pred", pt0, 1);
    chk("trained_target", ptg0, 16'h0040);
    advance();

    // EQ with Z=0, predicted taken
    resolve(16'h0010, 3'b001, 3'b000, 16'h0040, 1, 16'h0040);
    check_all();
    chk("nt_misp", mp0, 1);
    chk("nt_redirect", rd0, 16'h0014);
    chk("nt_actual", at0, 0);
    advance();
    idle();
    check_all();
    chk("nt_pred", pt0, 0);
    advance();

    // saturation: seven taken, then not-taken twice
    for (int k = 0; k < 7; k++) begin
      resolve(16'h0010, 3'b111, 3'b000, 16'h0040, 1, 16'h0040);
      check_all();
      advance();
    end
    resolve(16'h0010, 3'b001, 3'b000, 16'h0040, 1, 16'h0040);
    check_all();
    advance();
    idle();
    check_all();
    chk("sat_hold", pt0, 1);
    advance();
    resolve(16'h0010, 3'b001, 3'b000, 16'h0040, 1, 16'h0040);
    check_all();
    advance();
    idle();
    check_all();
    chk("sat_drop", pt0, 0);
    advance();
    resolve(16'h0010, 3'b111, 3'b000, 16'h0040, 0, 16'h0000);
    check_all();
    advance();

    // aliasing: 0x0050 shares the index of 0x0010 with a different tag
    idle();
    if_pc = 16'h0050;
    rs_valid = 1; rs_is_branch = 0; rs_pc = 16'h0050; rs_cond = 3'b111;
    rpt0 = 1; rpt1 = 1; rptg0 = 16'h0040; rptg1 = 16'h0040;
    check_all();
    chk("alias_tag", pt0, 0);
    chk("alias_misp", mp0, 1);
    chk("alias_redirect", rd0, 16'h0054);
    advance();
    idle();
    if_pc = 16'h0010;
    check_all();
    chk("alias_inval", pt0, 0);
    advance();

    // gshare history restore beats the simultaneous fetch shift
    if_pc = 16'h0030;
    resolve(16'h0020, 3'b111, 3'b000, 16'h0080, 0, 16'h0000);
    rh1 = 4'b0101;
    check_all();
    chk("ghr_misp", mp1, 1);
    advance();
    idle();
    if_valid = 0;
    check_all();
    chk("ghr_restore", ph1, 4'b1011);
    advance();

    // retrain, then reset with an update pending
    if_valid = 1; if_pc = 16'h0010;
    resolve(16'h0010, 3'b111, 3'b000, 16'h0040, 0, 16'h0000);
    check_all();
    advance();
    idle();
    check_all();
    chk("retrain", pt0, 1);
    advance();
    resolve(16'h0010, 3'b111, 3'b000, 16'h0040, 0, 16'h0000);
    rst = 1;
    check_all();
    advance();
    rst = 0;
    idle();
    check_all();
    chk("rst_clear", pt0, 0);
    chk("rst_ghr", ph1, 0);
    advance();

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      if_valid     = ($urandom_range(0, 3) != 0);
      if_stall     = ($urandom_range(0, 3) == 0);
      if_pc        = 16'($urandom_range(0, 31) * 4);
      rs_valid     = $urandom_range(0, 1);
      rs_is_branch = ($urandom_range(0, 3) != 0);
      rs_pc        = 16'($urandom_range(0, 31) * 4);
      rs_cond      = 3'($urandom_range(0, 7));
      rs_flags     = 3'($urandom_range(0, 7));
      rs_target    = 16'($urandom_range(1, 3) * 64);
      if ($urandom_range(0, 1) == 1) begin
        rpt0 = 1'(mlook(0, int'(rs_pc), mghr[0], tg)); rptg0 = 16'(tg); rh0 = 1'($urandom_range(0, 1));
      end else begin
        rpt0 = 1'($urandom_range(0, 1)); rptg0 = 16'($urandom_range(1, 3) * 64); rh0 = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 1) == 1) begin
        rpt1 = 1'(mlook(1, int'(rs_pc), mghr[1], tg)); rptg1 = 16'(tg); rh1 = 4'(mghr[1]);
      end else begin
        rpt1 = 1'($urandom_range(0, 1)); rptg1 = 16'($urandom_range(1, 3) * 64); rh1 = 4'($urandom_range(0, 15));
      end
      check_all();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
